// File: rtl/lcd_spi_fifo.sv
// lcd_spi_fifo
// ------------
// Transmit FIFO for an LCD link. The CPU pushes bytes tagged with a
// data/command (DC) bit; this block replays each byte into spi_controller
// through that controller's memory-bus slave port: optional DC write, DATA
// write, CTRL start write, then STATUS polling until the controller reports
// done. The head entry is popped only on done, so the reported level
// includes the byte currently on the wire.
//
// Ports
//   clk, reset            : clock, asynchronous active-high reset
//   address_in, sel_in,   : CPU slave port (0x0 TX, 0x4 STATUS, 0x8 CTRL)
//   read_in, write_mask_in,
//   write_value_in, read_value_out, ready_out
//   spi_*_out             : registered bus-master request to spi_controller
//   spi_read_value_in     : controller read data (bit1 done, bit0 busy)
//   spi_ready_in          : controller ready; access completes on sel && ready
//   irq_out               : only when LCD_FIFO_IRQ_EN is defined; registered
//                           level "FIFO empty, idle, and enabled by CTRL bit2"
module lcd_spi_fifo #(
    parameter logic [31:0] SPI_BASE   = 32'h0000_0000,
    parameter int          DEPTH      = 16,
    parameter int          ADDR_WIDTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address_in,
    input  logic        sel_in,
    input  logic        read_in,
    input  logic [3:0]  write_mask_in,
    input  logic [31:0] write_value_in,
    output logic [31:0] read_value_out,
    output logic        ready_out,
    output logic [31:0] spi_address_out,
    output logic        spi_sel_out,
    output logic        spi_read_out,
    output logic [3:0]  spi_write_mask_out,
    output logic [31:0] spi_write_value_out,
    input  logic [31:0] spi_read_value_in,
    input  logic        spi_ready_in
`ifdef LCD_FIFO_IRQ_EN
    ,
    output logic        irq_out
`endif
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR_DC   = 3'd1,
        S_WR_DATA = 3'd2,
        S_WR_CTRL = 3'd3,
        S_POLL    = 3'd4,
        S_GAP     = 3'd5
    } state_t;

    localparam logic [ADDR_WIDTH:0]   LVL_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0]   LVL_FULL = (ADDR_WIDTH+1)'(DEPTH);

    logic [8:0]            mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   level_q, level_d;
    logic                  overflow_q, overflow_d;
    state_t                state_q, state_d, ret_q, ret_d;
    logic [8:0]            entry_q, entry_d;
    logic                  last_dc_q, last_dc_d, dc_valid_q, dc_valid_d;
    logic                  flushed_q, flushed_d;
    logic [31:0]           spi_address_q, spi_address_d;
    logic                  spi_sel_q, spi_sel_d, spi_read_q, spi_read_d;
    logic [3:0]            spi_write_mask_q, spi_write_mask_d;
    logic [31:0]           spi_write_value_q, spi_write_value_d;

    logic [3:0] offset_s;
    logic       cpu_wr_s, push_req_s, ctrl_wr_s, flush_s, clr_ovf_s;
    logic       empty_s, full_s, busy_s, push_ok_s, pop_s, access_done_s;
    logic       unused_s;

    assign offset_s      = address_in[3:0];
    assign cpu_wr_s      = sel_in && (write_mask_in != 4'h0);
    assign push_req_s    = cpu_wr_s && (offset_s == 4'h0);
    assign ctrl_wr_s     = cpu_wr_s && (offset_s == 4'h8);
    assign flush_s       = ctrl_wr_s && write_value_in[0];
    assign clr_ovf_s     = ctrl_wr_s && write_value_in[1];
    assign empty_s       = (level_q == {(ADDR_WIDTH+1){1'b0}});
    assign full_s        = (level_q == LVL_FULL);
    assign busy_s        = (state_q != S_IDLE);
    // A flush in the same cycle takes precedence over a push.
    assign push_ok_s     = push_req_s && !full_s && !flush_s;
    assign access_done_s = spi_sel_q && spi_ready_in;
    assign unused_s      = ^{address_in[31:4], write_value_in[31:9],
                             spi_read_value_in[31:2], spi_read_value_in[0], read_in};

    assign ready_out      = sel_in;
    assign read_value_out = (sel_in && (offset_s == 4'h4))
        ? {{(32-ADDR_WIDTH-9){1'b0}}, level_q, 4'b0000, overflow_q, busy_s, full_s, empty_s}
        : 32'h0000_0000;

    // FIFO pointer, level and sticky overflow update.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        overflow_d = overflow_q;
        if (flush_s) begin
            wr_ptr_d = {ADDR_WIDTH{1'b0}};
            rd_ptr_d = {ADDR_WIDTH{1'b0}};
            level_d  = {(ADDR_WIDTH+1){1'b0}};
        end else begin
            wr_ptr_d = push_ok_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
            rd_ptr_d = pop_s ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
            case ({push_ok_s, pop_s})
                2'b10:   level_d = level_q + LVL_ONE;
                2'b01:   level_d = level_q - LVL_ONE;
                default: level_d = level_q;
            endcase
        end
        // A push into a full FIFO is lost even if a pop frees a slot this cycle.
        if (clr_ovf_s) begin
            overflow_d = 1'b0;
        end else if (push_req_s && full_s) begin
            overflow_d = 1'b1;
        end else begin
            overflow_d = overflow_q;
        end
    end

    // FIFO storage; contents are meaningless until the pointers say otherwise.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q] <= write_value_in[8:0];
        end
    end

    // Sequencer next-state: access states wait for sel && ready, every access is followed by GAP.
    always_comb begin
        state_d    = state_q;
        ret_d      = ret_q;
        entry_d    = entry_q;
        last_dc_d  = last_dc_q;
        dc_valid_d = dc_valid_q;
        flushed_d  = flushed_q;
        pop_s      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!empty_s) begin
                    entry_d   = mem_q[rd_ptr_q];
                    flushed_d = 1'b0;
                    if (!dc_valid_q || (mem_q[rd_ptr_q][8] != last_dc_q)) begin
                        state_d = S_WR_DC;
                    end else begin
                        state_d = S_WR_DATA;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WR_DC: begin
                if (access_done_s) begin
                    last_dc_d  = entry_q[8];
                    dc_valid_d = 1'b1;
                    ret_d      = S_WR_DATA;
                    state_d    = S_GAP;
                end else begin
                    state_d = S_WR_DC;
                end
            end
            S_WR_DATA: begin
                if (access_done_s) begin
                    ret_d   = S_WR_CTRL;
                    state_d = S_GAP;
                end else begin
                    state_d = S_WR_DATA;
                end
            end
            S_WR_CTRL: begin
                if (access_done_s) begin
                    ret_d   = S_POLL;
                    state_d = S_GAP;
                end else begin
                    state_d = S_WR_CTRL;
                end
            end
            S_POLL: begin
                if (access_done_s) begin
                    state_d = S_GAP;
                    if (spi_read_value_in[1]) begin
                        // The entry was already discarded if a flush hit after latching.
                        pop_s = !flushed_q && !flush_s;
                        ret_d = S_IDLE;
                    end else begin
                        ret_d = S_POLL;
                    end
                end else begin
                    state_d = S_POLL;
                end
            end
            S_GAP:   state_d = ret_q;
            default: state_d = S_IDLE;
        endcase
        if (flush_s) begin
            flushed_d = 1'b1;
        end else begin
            flushed_d = flushed_d;
        end
    end

    // Master request for the upcoming state, so the bus is registered yet
    // already valid in the first cycle of each access state.
    always_comb begin
        spi_sel_d         = 1'b0;
        spi_read_d        = 1'b0;
        spi_write_mask_d  = 4'h0;
        spi_address_d     = 32'h0000_0000;
        spi_write_value_d = 32'h0000_0000;
        case (state_d)
            S_WR_DC: begin
                spi_sel_d         = 1'b1;
                spi_write_mask_d  = 4'hF;
                spi_address_d     = SPI_BASE + 32'h0000_000C;
                spi_write_value_d = {31'd0, entry_d[8]};
            end
            S_WR_DATA: begin
                spi_sel_d         = 1'b1;
                spi_write_mask_d  = 4'hF;
                spi_address_d     = SPI_BASE;
                spi_write_value_d = {24'd0, entry_d[7:0]};
            end
            S_WR_CTRL: begin
                spi_sel_d         = 1'b1;
                spi_write_mask_d  = 4'hF;
                spi_address_d     = SPI_BASE + 32'h0000_0004;
                spi_write_value_d = 32'h0000_0001;
            end
            S_POLL: begin
                spi_sel_d     = 1'b1;
                spi_read_d    = 1'b1;
                spi_address_d = SPI_BASE + 32'h0000_0008;
            end
            default: begin
                spi_sel_d = 1'b0;
            end
        endcase
    end

    // State, FIFO bookkeeping and master output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q          <= {ADDR_WIDTH{1'b0}};
            rd_ptr_q          <= {ADDR_WIDTH{1'b0}};
            level_q           <= {(ADDR_WIDTH+1){1'b0}};
            overflow_q        <= 1'b0;
            state_q           <= S_IDLE;
            ret_q             <= S_IDLE;
            entry_q           <= 9'd0;
            last_dc_q         <= 1'b0;
            dc_valid_q        <= 1'b0;
            flushed_q         <= 1'b0;
            spi_sel_q         <= 1'b0;
            spi_read_q        <= 1'b0;
            spi_write_mask_q  <= 4'h0;
            spi_address_q     <= 32'h0000_0000;
            spi_write_value_q <= 32'h0000_0000;
        end else begin
            wr_ptr_q          <= wr_ptr_d;
            rd_ptr_q          <= rd_ptr_d;
            level_q           <= level_d;
            overflow_q        <= overflow_d;
            state_q           <= state_d;
            ret_q             <= ret_d;
            entry_q           <= entry_d;
            last_dc_q         <= last_dc_d;
            dc_valid_q        <= dc_valid_d;
            flushed_q         <= flushed_d;
            spi_sel_q         <= spi_sel_d;
            spi_read_q        <= spi_read_d;
            spi_write_mask_q  <= spi_write_mask_d;
            spi_address_q     <= spi_address_d;
            spi_write_value_q <= spi_write_value_d;
        end
    end

    assign spi_sel_out         = spi_sel_q;
    assign spi_read_out        = spi_read_q;
    assign spi_write_mask_out  = spi_write_mask_q;
    assign spi_address_out     = spi_address_q;
    assign spi_write_value_out = spi_write_value_q;

`ifdef LCD_FIFO_IRQ_EN
    logic irq_enable_q, irq_enable_d, irq_q, irq_d;

    // Interrupt enable tracks CTRL bit2; the request is a level while drained and idle.
    always_comb begin
        if (ctrl_wr_s) begin
            irq_enable_d = write_value_in[2];
        end else begin
            irq_enable_d = irq_enable_q;
        end
        irq_d = empty_s && (state_q == S_IDLE) && irq_enable_q;
    end

    // Interrupt registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_enable_q <= 1'b0;
            irq_q        <= 1'b0;
        end else begin
            irq_enable_q <= irq_enable_d;
            irq_q        <= irq_d;
        end
    end

    assign irq_out = irq_q;
`endif

endmodule
